// File: rtl/pwm_rv_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM encoding,
// bus widths and the timeout / error-data defaults.
package pwm_rv_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = 4;

  localparam int                    DEF_TIMEOUT_CYCLES = 64;
  localparam logic [BUS_DATA_W-1:0] DEF_ERR_RDATA      = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational from req; the
// last-grant register moves only when update is high and a grant is issued.
module bus_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // High when master 1 owned the bus last; reset so master 0 wins first.
  logic r_last_m1;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last_m1 ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_m1 <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      r_last_m1 <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave memory bus arbiter (IDLE/BUSY/RESP FSM).
// Optional slave timeout is enabled by defining BUS_TIMEOUT_EN.
module mem_bus_arbiter
  import pwm_rv_bus_pkg::*;
#(
  parameter int                    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [BUS_DATA_W-1:0] ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_valid_i,
  input  logic [BUS_ADDR_W-1:0] m0_addr_i,
  input  logic [BUS_DATA_W-1:0] m0_wdata_i,
  input  logic [BUS_STRB_W-1:0] m0_wstrb_i,
  output logic                  m0_ready_o,
  output logic [BUS_DATA_W-1:0] m0_rdata_o,
  input  logic                  m1_valid_i,
  input  logic [BUS_ADDR_W-1:0] m1_addr_i,
  input  logic [BUS_DATA_W-1:0] m1_wdata_i,
  input  logic [BUS_STRB_W-1:0] m1_wstrb_i,
  output logic                  m1_ready_o,
  output logic [BUS_DATA_W-1:0] m1_rdata_o,
  output logic                  s_valid_o,
  output logic [BUS_ADDR_W-1:0] s_addr_o,
  output logic [BUS_DATA_W-1:0] s_wdata_o,
  output logic [BUS_STRB_W-1:0] s_wstrb_o,
  input  logic                  s_ready_i,
  input  logic [BUS_DATA_W-1:0] s_rdata_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a master holds valid and its request fields stable until it
  // sees its ready for one cycle; the slave side uses the same rule, with
  // s_ready_i high for the single cycle in which s_rdata_i is valid.
  bus_state_e            r_state, w_next;
  logic [1:0]            r_grant;
  logic [BUS_ADDR_W-1:0] r_addr;
  logic [BUS_DATA_W-1:0] r_wdata;
  logic [BUS_STRB_W-1:0] r_wstrb;
  logic [BUS_DATA_W-1:0] r_m0_rdata, r_m1_rdata;

  logic [1:0]            w_arb_req, w_arb_gnt;
  logic                  w_arb_upd, w_tmo_hit, w_busy_done;
  logic [BUS_DATA_W-1:0] w_resp_data;

  // Requests reach the arbiter only in IDLE, so a valid still high during
  // its own ready cycle cannot be granted a second time.
  assign w_arb_req = (r_state == ST_IDLE) ? {m1_valid_i, m0_valid_i} : 2'b00;
  assign w_arb_upd = (r_state == ST_IDLE);

  bus_rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req    (w_arb_req),
    .update (w_arb_upd),
    .gnt    (w_arb_gnt)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout;

  assign w_tmo_hit = (r_state == ST_BUSY) && !s_ready_i &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo_hit;
      if (w_arb_gnt != 2'b00) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == ST_BUSY) && !s_ready_i &&
                   (r_tmo_cnt != TMO_W'(TIMEOUT_CYCLES))) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // A real slave response wins over a timeout landing in the same cycle.
  assign w_busy_done = (r_state == ST_BUSY) && (s_ready_i || w_tmo_hit);
  assign w_resp_data = s_ready_i ? s_rdata_i : ERR_RDATA;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_arb_gnt != 2'b00) w_next = ST_BUSY;
      ST_BUSY: if (w_busy_done) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_grant    <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_arb_gnt != 2'b00) begin
        r_grant <= w_arb_gnt;
        if (w_arb_gnt[1]) begin
          r_addr  <= m1_addr_i;
          r_wdata <= m1_wdata_i;
          r_wstrb <= m1_wstrb_i;
        end else begin
          r_addr  <= m0_addr_i;
          r_wdata <= m0_wdata_i;
          r_wstrb <= m0_wstrb_i;
        end
      end else if (r_state == ST_RESP) begin
        r_grant <= 2'b00;
      end
      if (w_busy_done && r_grant[0]) r_m0_rdata <= w_resp_data;
      if (w_busy_done && r_grant[1]) r_m1_rdata <= w_resp_data;
    end
  end

  assign s_valid_o   = (r_state == ST_BUSY);
  assign s_addr_o    = r_addr;
  assign s_wdata_o   = r_wdata;
  assign s_wstrb_o   = r_wstrb;
  assign m0_ready_o  = (r_state == ST_RESP) && r_grant[0];
  assign m1_ready_o  = (r_state == ST_RESP) && r_grant[1];
  assign m0_rdata_o  = r_m0_rdata;
  assign m1_rdata_o  = r_m1_rdata;
  assign grant_o     = r_grant;
  assign dbg_state_o = r_state;

endmodule
